// File: rtl/traffic_lamp_monitor_if.sv
// Lamp-drive bundle for the two-approach traffic controller.
// The controller side drives it; the monitor side only listens.
interface traffic_lamp_monitor_if;
  logic red1;
  logic yellow1;
  logic green1;
  logic red2;
  logic yellow2;
  logic green2;

  modport master (
    output red1, yellow1, green1,
    output red2, yellow2, green2
  );

  modport slave (
    input red1, yellow1, green1,
    input red2, yellow2, green2
  );
endinterface

// File: rtl/traffic_lamp_monitor.sv
// Independent lamp checker; latches the first fault and forces flash.
// Optional minimum-dwell check enabled by LAMP_DWELL_CHECK_EN.
module traffic_lamp_monitor #(
  parameter int GRN_MIN = 3,
  parameter int YEL_MIN = 2,
  parameter int RED_MIN = 1,
  parameter int DW_W    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   monitor_en,
  input  logic                   clear_fault,
  traffic_lamp_monitor_if.slave  lamps,
  output logic [1:0]             phase1,
  output logic [1:0]             phase2,
  output logic                   fault,
  output logic [2:0]             fault_code,
  output logic                   force_flash
);

  typedef enum logic [1:0] {
    PH_RED    = 2'd0,
    PH_GREEN  = 2'd1,
    PH_YELLOW = 2'd2,
    PH_INV    = 2'd3
  } phase_t;

  if (GRN_MIN > 2**DW_W - 1 ||
      YEL_MIN > 2**DW_W - 1 ||
      RED_MIN > 2**DW_W - 1) begin : g_min_range
    $error("dwell minimum exceeds counter range");
  end

  logic   s_r1, s_y1, s_g1;
  logic   s_r2, s_y2, s_g2;
  logic   s_vld;
  logic   primed;
  phase_t ph1_q, ph2_q;
  phase_t d1, d2;
  logic   chk_on, ord_on;
  logic   conflict;
  logic   legal1, legal2;
  logic   [2:0] det_code;

  function automatic phase_t decode(
    input logic r,
    input logic y,
    input logic g
  );
    phase_t p;
    case ({r, y, g})
      3'b100:  p = PH_RED;
      3'b010:  p = PH_YELLOW;
      3'b001:  p = PH_GREEN;
      default: p = PH_INV;
    endcase
    return p;
  endfunction

  function automatic logic legal(
    input phase_t p,
    input phase_t n
  );
    return (p == n) ||
           (p == PH_GREEN  && n == PH_YELLOW) ||
           (p == PH_YELLOW && n == PH_RED) ||
           (p == PH_RED    && n == PH_GREEN);
  endfunction

  // Register the raw lamp drives; s_vld marks that s_* holds real data.
  always_ff @(posedge clk) begin
    if (rst) begin
      {s_r1, s_y1, s_g1} <= '0;
      {s_r2, s_y2, s_g2} <= '0;
      s_vld <= 1'b0;
    end else begin
      s_r1  <= lamps.red1;
      s_y1  <= lamps.yellow1;
      s_g1  <= lamps.green1;
      s_r2  <= lamps.red2;
      s_y2  <= lamps.yellow2;
      s_g2  <= lamps.green2;
      s_vld <= 1'b1;
    end
  end

  assign d1       = decode(s_r1, s_y1, s_g1);
  assign d2       = decode(s_r2, s_y2, s_g2);
  assign chk_on   = monitor_en && s_vld;
  assign ord_on   = chk_on && primed;
  assign conflict = (d1 != PH_RED) && (d2 != PH_RED);
  assign legal1   = legal(ph1_q, d1);
  assign legal2   = legal(ph2_q, d2);

`ifdef LAMP_DWELL_CHECK_EN
  localparam logic [DW_W-1:0] GRN_W = DW_W'(GRN_MIN);
  localparam logic [DW_W-1:0] YEL_W = DW_W'(YEL_MIN);
  localparam logic [DW_W-1:0] RED_W = DW_W'(RED_MIN);

  logic [DW_W-1:0] cnt1, cnt2;
  logic            known1, known2;
  logic            short1, short2;

  function automatic logic [DW_W-1:0] min_of(
    input phase_t p
  );
    logic [DW_W-1:0] m;
    unique case (1'b1)
      p == PH_GREEN:  m = GRN_W;
      p == PH_YELLOW: m = YEL_W;
      p == PH_RED:    m = RED_W;
      default:        m = '0;
    endcase
    return m;
  endfunction

  assign short1 = known1 && (d1 != ph1_q) && legal1 &&
                  (cnt1 < min_of(ph1_q));
  assign short2 = known2 && (d2 != ph2_q) && legal2 &&
                  (cnt2 < min_of(ph2_q));

  // Per-approach dwell counters; a phase only counts once it was
  // entered while the monitor was primed.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt1   <= '0;
      cnt2   <= '0;
      known1 <= 1'b0;
      known2 <= 1'b0;
    end else if (s_vld) begin
      if (d1 != ph1_q)
        cnt1 <= DW_W'(1);
      else if (cnt1 != '1)
        cnt1 <= cnt1 + 1'b1;
      if (d2 != ph2_q)
        cnt2 <= DW_W'(1);
      else if (cnt2 != '1)
        cnt2 <= cnt2 + 1'b1;
      known1 <= ord_on && (known1 || d1 != ph1_q);
      known2 <= ord_on && (known2 || d2 != ph2_q);
    end
  end
`endif

  // Pick the highest-priority fault seen this cycle, 0 if none.
  always_comb begin
    det_code = 3'd0;
    if (chk_on) begin
      if (conflict)
        det_code = 3'd3;
      else if (d1 == PH_INV)
        det_code = 3'd1;
      else if (d2 == PH_INV)
        det_code = 3'd2;
      else if (ord_on && !legal1)
        det_code = 3'd4;
      else if (ord_on && !legal2)
        det_code = 3'd5;
`ifdef LAMP_DWELL_CHECK_EN
      else if (ord_on && short1)
        det_code = 3'd6;
      else if (ord_on && short2)
        det_code = 3'd7;
`endif
    end
  end

  // Decoded phases follow the samples regardless of monitor_en.
  always_ff @(posedge clk) begin
    if (rst) begin
      ph1_q <= PH_RED;
      ph2_q <= PH_RED;
    end else if (s_vld) begin
      ph1_q <= d1;
      ph2_q <= d2;
    end
  end

  // Primed after the first checked cycle; dropped whenever disabled.
  always_ff @(posedge clk) begin
    if (rst || !monitor_en)
      primed <= 1'b0;
    else if (s_vld)
      primed <= 1'b1;
  end

  // First-fault capture; a fresh fault beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      fault      <= 1'b0;
      fault_code <= 3'd0;
    end else if (det_code != 3'd0 && (!fault || clear_fault)) begin
      fault      <= 1'b1;
      fault_code <= det_code;
    end else if (clear_fault) begin
      fault      <= 1'b0;
      fault_code <= 3'd0;
    end
  end

  assign phase1      = ph1_q;
  assign phase2      = ph2_q;
  assign force_flash = fault;

endmodule
